mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arbiter_resp_pipe.sv | 47 ++++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// owner encoding, funct3 size codes and the in-flight tag record.
package mem_arbiter_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
        logic   we;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic logic misaligned(input logic [2:0] size,
                                        input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_B, SZ_BU: bad = 1'b0;
            SZ_H, SZ_HU: bad = lo[0];
            SZ_W:        bad = (lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter_resp_pipe.sv
// Fixed-latency response pipeline: one tag per grant, retired
// MEM_LAT cycles later and steered back to its owner.
module resp_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  tag_t        tag_in,
    input  logic [31:0] m_rdata,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err
);

    tag_t [MEM_LAT-1:0] pipe;
    tag_t               head;
    logic [31:0]        rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= '0;
        end else begin
            for (int k = MEM_LAT - 1; k > 0; k--) begin
                pipe[k] <= pipe[k-1];
            end
            pipe[0] <= tag_in;
        end
    end

    // Faults and write acks carry no data; only clean reads pass RAM data.
    always_comb begin
        head     = pipe[MEM_LAT-1];
        rdata    = (head.valid && !head.err && !head.we) ? m_rdata : '0;
        i_rvalid = head.valid && (head.owner == OWN_I);
        d_rvalid = head.valid && (head.owner == OWN_D);
        i_err    = i_rvalid && head.err;
        d_err    = d_rvalid && head.err;
        i_rdata  = i_rvalid ? rdata : '0;
        d_rdata  = d_rvalid ? rdata : '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency RAM port between
// instruction fetch and data access.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_size,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    logic   armed;
    owner_e last_grant;
    logic   mis_i;
    logic   mis_d;
    tag_t   tag_in;

    // armed holds off grants for the first cycle out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed      <= 1'b0;
            last_grant <= OWN_D;
        end else begin
            armed <= 1'b1;
            if (i_gnt) begin
                last_grant <= OWN_I;
            end else if (d_gnt) begin
                last_grant <= OWN_D;
            end
        end
    end

    always_comb begin
        mis_i = (i_addr[1:0] != 2'b00);
        mis_d = misaligned(d_size, d_addr[1:0]);
        i_gnt = armed && i_req && !(d_req && last_grant == OWN_I);
        d_gnt = armed && d_req && !(i_req && last_grant == OWN_D);
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_size  = '0;
        m_wdata = '0;
        tag_in  = '0;
        unique case (1'b1)
            i_gnt: begin
                m_en   = !mis_i;
                m_addr = mis_i ? '0 : i_addr;
                m_size = mis_i ? 3'b000 : SZ_W;
                tag_in = '{valid: 1'b1, owner: OWN_I, err: mis_i, we: 1'b0};
            end
            d_gnt: begin
                m_en    = !mis_d;
                m_we    = !mis_d && d_we;
                m_addr  = mis_d ? '0 : d_addr;
                m_size  = mis_d ? 3'b000 : d_size;
                m_wdata = mis_d ? '0 : d_wdata;
                tag_in  = '{valid: 1'b1, owner: OWN_D, err: mis_d, we: d_we};
            end
            default: begin
                m_en = 1'b0;
            end
        endcase
    end

    resp_pipe #(
        .MEM_LAT(MEM_LAT)
    ) u_resp (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .m_rdata (m_rdata),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .i_err   (i_err),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .d_err   (d_err)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1,2,3) share one stimulus
// stream, each backed by its own fixed-latency RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [13:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [13:0] d_addr;
    logic [31:0] d_wdata;

    logic [2:0]  i_gnt_v, i_rvalid_v, i_err_v;
    logic [2:0]  d_gnt_v, d_rvalid_v, d_err_v;
    logic [2:0]  m_en_v, m_we_v;
    logic [31:0] i_rdata_v [3];
    logic [31:0] d_rdata_v [3];
    logic [31:0] m_wdata_v [3];
    logic [31:0] m_rdata_v [3];
    logic [13:0] m_addr_v  [3];
    logic [2:0]  m_size_v  [3];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return (a == 14'h0040) ? 32'h0000_0013 : {16'hC0DE, 2'b00, a};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = g + 1;
        logic [13:0] ad [L];
        always @(posedge clk) begin
            ad[0] <= m_addr_v[g];
            for (int k = 1; k < L; k++) ad[k] <= ad[k-1];
        end
        assign m_rdata_v[g] = mem_word(ad[L-1]);
        mem_arbiter #(.ADDR_W(14), .MEM_LAT(L)) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .i_req   (i_req),
            .i_addr  (i_addr),
            .i_gnt   (i_gnt_v[g]),
            .i_rvalid(i_rvalid_v[g]),
            .i_rdata (i_rdata_v[g]),
            .i_err   (i_err_v[g]),
            .d_req   (d_req),
            .d_we    (d_we),
            .d_size  (d_size),
            .d_addr  (d_addr),
            .d_wdata (d_wdata),
            .d_gnt   (d_gnt_v[g]),
            .d_rvalid(d_rvalid_v[g]),
            .d_rdata (d_rdata_v[g]),
            .d_err   (d_err_v[g]),
            .m_en    (m_en_v[g]),
            .m_we    (m_we_v[g]),
            .m_addr  (m_addr_v[g]),
            .m_size  (m_size_v[g]),
            .m_wdata (m_wdata_v[g]),
            .m_rdata (m_rdata_v[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        bit [5:0] e_ig, e_dg, e_irv, e_drv;
        reset_n = 1'b0;
        i_req   = 1'b1;
        i_addr  = 14'h0040;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_size  = 3'b010;
        d_addr  = 14'h0080;
        d_wdata = 32'h0000_1234;

        // reset forces everything quiet even with requests pending
        mid();
        chk("rst_i_gnt", i_gnt_v[0], 0);
        chk("rst_d_gnt", d_gnt_v[0], 0);
        chk("rst_m_en", m_en_v[0], 0);
        chk("rst_m_we", m_we_v[0], 0);
        chk("rst_m_addr", m_addr_v[0], 0);
        chk("rst_m_size", m_size_v[0], 0);
        chk("rst_m_wdata", m_wdata_v[0], 0);
        chk("rst_i_rvalid", i_rvalid_v[0], 0);
        chk("rst_d_rvalid", d_rvalid_v[0], 0);
        chk("rst_i_rdata", i_rdata_v[0], 0);
        tick();
        tick();
        reset_n = 1'b1;

        // dual request from reset: none, I, D, I, D
        e_ig  = 6'b001010;
        e_dg  = 6'b010100;
        e_irv = 6'b010100;
        e_drv = 6'b101000;
        for (int c = 0; c < 6; c++) begin
            mid();
            chk($sformatf("rr_i_gnt_c%0d", c), i_gnt_v[0], e_ig[c]);
            chk($sformatf("rr_d_gnt_c%0d", c), d_gnt_v[0], e_dg[c]);
            chk($sformatf("rr_i_rv_c%0d", c), i_rvalid_v[0], e_irv[c]);
            chk($sformatf("rr_d_rv_c%0d", c), d_rvalid_v[0], e_drv[c]);
            if (e_irv[c])
                chk($sformatf("rr_i_rdata_c%0d", c), i_rdata_v[0], 32'h13);
            if (e_drv[c])
                chk($sformatf("rr_d_rdata_c%0d", c), d_rdata_v[0],
                    mem_word(14'h0080));
            tick();
            if (c == 4) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end

        // single fetch, MEM_LAT=1
        i_req  = 1'b1;
        i_addr = 14'h0040;
        mid();
        chk("f1_i_gnt", i_gnt_v[0], 1);
        chk("f1_d_gnt", d_gnt_v[0], 0);
        chk("f1_m_en", m_en_v[0], 1);
        chk("f1_m_addr", m_addr_v[0], 32'h40);
        chk("f1_m_we", m_we_v[0], 0);
        chk("f1_m_size", m_size_v[0], 3'b010);
        tick();
        i_req   = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_size  = 3'b010;
        d_addr  = 14'h0102;
        d_wdata = 32'h55;
        mid();
        chk("f1_i_rvalid", i_rvalid_v[0], 1);
        chk("f1_i_rdata", i_rdata_v[0], 32'h13);
        chk("f1_i_err", i_err_v[0], 0);
        chk("mw_d_gnt", d_gnt_v[0], 1);
        chk("mw_m_en", m_en_v[0], 0);
        tick();
        d_size  = 3'b000;
        d_addr  = 14'h0103;
        d_wdata = 32'hAB;
        mid();
        chk("mw_d_rvalid", d_rvalid_v[0], 1);
        chk("mw_d_err", d_err_v[0], 1);
        chk("mw_d_rdata", d_rdata_v[0], 0);
        chk("sb_d_gnt", d_gnt_v[0], 1);
        chk("sb_m_en", m_en_v[0], 1);
        chk("sb_m_we", m_we_v[0], 1);
        chk("sb_m_size", m_size_v[0], 3'b000);
        chk("sb_m_addr", m_addr_v[0], 32'h103);
        chk("sb_m_wdata", m_wdata_v[0], 32'hAB);
        tick();
        d_we   = 1'b0;
        d_size = 3'b011;
        d_addr = 14'h0000;
        mid();
        chk("sb_d_rvalid", d_rvalid_v[0], 1);
        chk("sb_d_err", d_err_v[0], 0);
        chk("sb_d_rdata", d_rdata_v[0], 0);
        chk("sz3_d_gnt", d_gnt_v[0], 1);
        chk("sz3_m_en", m_en_v[0], 0);
        tick();
        d_req  = 1'b0;
        i_req  = 1'b1;
        i_addr = 14'h0042;
        mid();
        chk("sz3_d_rvalid", d_rvalid_v[0], 1);
        chk("sz3_d_err", d_err_v[0], 1);
        chk("sz3_d_rdata", d_rdata_v[0], 0);
        chk("mf_i_gnt", i_gnt_v[0], 1);
        chk("mf_m_en", m_en_v[0], 0);
        tick();
        i_req = 1'b0;
        mid();
        chk("mf_i_rvalid", i_rvalid_v[0], 1);
        chk("mf_i_err", i_err_v[0], 1);
        chk("mf_i_rdata", i_rdata_v[0], 0);
        chk("idle_d_rvalid", d_rvalid_v[0], 0);
        chk("idle_d_err", d_err_v[0], 0);
        tick();

        // three back-to-back fetches on the MEM_LAT=3 instance
        for (int k = 0; k < 7; k++) begin
            i_req  = (k < 3);
            i_addr = 14'h0040 + 14'(4 * k);
            mid();
            if (k < 3)
                chk($sformatf("bb_i_gnt_%0d", k), i_gnt_v[2], 1);
            if (k >= 2) begin
                chk($sformatf("bb_i_rv_%0d", k), i_rvalid_v[2],
                    (k >= 3 && k <= 5));
                if (k >= 3 && k <= 5)
                    chk($sformatf("bb_i_rdata_%0d", k), i_rdata_v[2],
                        mem_word(14'h0040 + 14'(4 * (k - 3))));
            end
            tick();
        end

        // reset one cycle after a legal grant (MEM_LAT=2)
        i_req  = 1'b1;
        i_addr = 14'h0040;
        mid();
        chk("rf_i_gnt", i_gnt_v[1], 1);
        tick();
        reset_n = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_size  = 3'b010;
        d_addr  = 14'h0080;
        mid();
        chk("rf_rst_i_gnt", i_gnt_v[1], 0);
        chk("rf_rst_m_en", m_en_v[1], 0);
        chk("rf_rst_i_rv", i_rvalid_v[1], 0);
        tick();
        reset_n = 1'b1;
        mid();
        chk("rf_rel_i_gnt", i_gnt_v[1], 0);
        chk("rf_rel_d_gnt", d_gnt_v[1], 0);
        chk("rf_rel_i_rv", i_rvalid_v[1], 0);
        tick();
        mid();
        chk("rf_first_i_gnt", i_gnt_v[1], 1);
        chk("rf_first_d_gnt", d_gnt_v[1], 0);
        chk("rf_stale_rv2", i_rvalid_v[1], 0);
        chk("rf_stale_rv3", i_rvalid_v[2], 0);
        tick();
        mid();
        chk("rf_next_d_gnt", d_gnt_v[1], 1);
        chk("rf_quiet_rv", i_rvalid_v[1], 0);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        mid();
        chk("rf_new_i_rv", i_rvalid_v[1], 1);
        chk("rf_new_i_rdata", i_rdata_v[1], 32'h13);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
